// File: rtl/collatz_sweep_driver.sv
// rtl/collatz_sweep_driver.sv - sweeps n over an inclusive range through one collatz core call per value
// Tracks the largest returned step count and its n; a watchdog aborts hung calls by resetting the core.
module collatz_sweep_driver #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int ABORT_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        ready,
    output logic        finish,
    input  logic [31:0] n_first,
    input  logic [31:0] n_last,
    output logic [31:0] max_steps,
    output logic [31:0] max_n,
    output logic [15:0] timeouts,
    output logic        core_start,
    input  logic        core_ready,
    input  logic        core_finish,
    input  logic [31:0] core_return_val,
    output logic [31:0] core_n,
    output logic        core_reset
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int AW = $clog2(ABORT_CYCLES) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW-1:0] ABORT_LAST = AW'(ABORT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ABORT,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   last_q, last_d;
    logic [31:0]   cur_n_q, cur_n_d;
    logic [31:0]   max_steps_q, max_steps_d;
    logic [31:0]   max_n_q, max_n_d;
    logic [15:0]   timeouts_q, timeouts_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [AW-1:0] abort_q, abort_d;
    logic          advance;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            last_q      <= '0;
            cur_n_q     <= '0;
            max_steps_q <= '0;
            max_n_q     <= '0;
            timeouts_q  <= '0;
            timer_q     <= '0;
            abort_q     <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cur_n_q     <= cur_n_d;
            max_steps_q <= max_steps_d;
            max_n_q     <= max_n_d;
            timeouts_q  <= timeouts_d;
            timer_q     <= timer_d;
            abort_q     <= abort_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cur_n_d     = cur_n_q;
        max_steps_d = max_steps_q;
        max_n_d     = max_n_q;
        timeouts_d  = timeouts_q;
        timer_d     = timer_q;
        abort_d     = abort_q;
        advance     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    last_d      = n_last;
                    cur_n_d     = n_first;
                    max_steps_d = '0;
                    max_n_d     = '0;
                    timeouts_d  = '0;
                    state_d     = (n_last < n_first) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (core_ready) begin
                    timer_d = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A result arriving on the timeout cycle is still accepted.
                if (core_finish) begin
                    if (core_return_val > max_steps_q) begin
                        max_steps_d = core_return_val;
                        max_n_d     = cur_n_q;
                    end
                    advance = 1'b1;
                end else if (timer_q == TIMER_LAST) begin
                    abort_d = '0;
                    state_d = ABORT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ABORT: begin
                if (abort_q == '0 && timeouts_q != 16'hFFFF) begin
                    timeouts_d = timeouts_q + 16'd1;
                end
                if (abort_q == ABORT_LAST) begin
                    advance = 1'b1;
                end else begin
                    abort_d = abort_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Equality is checked before incrementing so a sweep ending at 32'hFFFFFFFF never wraps.
        if (advance) begin
            if (cur_n_q == last_q) begin
                state_d = DONE;
            end else begin
                cur_n_d = cur_n_q + 32'd1;
                state_d = ISSUE;
            end
        end
    end

    assign ready      = (state_q == IDLE);
    assign finish     = (state_q == DONE);
    assign core_start = (state_q == ISSUE);
    assign core_n     = cur_n_q;
    assign core_reset = ~reset | (state_q == ABORT);
    assign max_steps  = max_steps_q;
    assign max_n      = max_n_q;
    assign timeouts   = timeouts_q;

endmodule
